// File: rtl/color_select_ctrl.sv
// Two-button colour selector: synchronized, debounced "next" and "load" presses
// step or load a 3-bit RGB index, with a one-cycle strobe whenever it is written.
module color_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       Pixel_clock,
  input  logic       Reset,
  input  logic       btn_next,
  input  logic       btn_load,
  input  logic [2:0] sw_rgb,
  output logic       R_sel,
  output logic       G_sel,
  output logic       B_sel,
  output logic       change_color
);

  localparam logic [1:0]  RELEASED  = 2'd0;
  localparam logic [1:0]  PRESS_CHK = 2'd1;
  localparam logic [1:0]  HELD      = 2'd2;
  localparam logic [1:0]  REL_CHK   = 2'd3;
  localparam logic [17:0] CNT_LAST  = 18'(DEBOUNCE_CYCLES - 1);

  // Button vectors: bit 0 = next, bit 1 = load.
  logic [1:0]  sync1_d, sync1_q, sync2_q;
  logic [1:0]  st_d   [2];
  logic [1:0]  st_q   [2];
  logic [17:0] cnt_d  [2];
  logic [17:0] cnt_q  [2];
  logic [1:0]  press_ev;
  logic [2:0]  index_d, index_q;
  logic        change_d, change_q;

  always_comb begin
    sync1_d = {btn_load, btn_next};
    for (int b = 0; b < 2; b++) begin
      st_d[b]     = st_q[b];
      cnt_d[b]    = cnt_q[b];
      press_ev[b] = 1'b0;
      case (st_q[b])
        RELEASED: begin
          if (sync2_q[b]) begin
            st_d[b]  = PRESS_CHK;
            cnt_d[b] = '0;
          end
        end
        PRESS_CHK: begin
          if (!sync2_q[b]) begin
            st_d[b] = RELEASED;
          end else if (cnt_q[b] == CNT_LAST) begin
            st_d[b]     = HELD;
            press_ev[b] = 1'b1;
          end else begin
            cnt_d[b] = cnt_q[b] + 18'd1;
          end
        end
        HELD: begin
          if (!sync2_q[b]) begin
            st_d[b]  = REL_CHK;
            cnt_d[b] = '0;
          end
        end
        REL_CHK: begin
          if (sync2_q[b]) begin
            st_d[b] = HELD;
          end else if (cnt_q[b] == CNT_LAST) begin
            st_d[b] = RELEASED;
          end else begin
            cnt_d[b] = cnt_q[b] + 18'd1;
          end
        end
        default: st_d[b] = RELEASED;
      endcase
    end

    // A load in the same cycle as a next press overrides the increment.
    index_d = index_q;
    if (press_ev[1]) begin
      index_d = sw_rgb;
    end else if (press_ev[0]) begin
      index_d = index_q + 3'd1;
    end
    change_d = |press_ev;
  end

  always_ff @(posedge Pixel_clock or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= RELEASED;
        cnt_q[b] <= '0;
      end
      index_q  <= '0;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync1_q;
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= st_d[b];
        cnt_q[b] <= cnt_d[b];
      end
      index_q  <= index_d;
      change_q <= change_d;
    end
  end

  assign R_sel        = index_q[2];
  assign G_sel        = index_q[1];
  assign B_sel        = index_q[0];
  assign change_color = change_q;

endmodule

// File: tb/tb_color_select_ctrl.sv
// Bench for color_select_ctrl with DEBOUNCE_CYCLES=4: directed scenarios plus
// random button activity, checked against a run-length reference model.
module tb_color_select_ctrl;

  localparam int D = 4;

  logic       Pixel_clock = 1'b0;
  logic       Reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_load = 1'b0;
  logic [2:0] sw_rgb = 3'b000;
  logic       R_sel, G_sel, B_sel, change_color;

  int n_checks = 0;
  int n_fail   = 0;

  color_select_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .Pixel_clock (Pixel_clock),
    .Reset       (Reset),
    .btn_next    (btn_next),
    .btn_load    (btn_load),
    .sw_rgb      (sw_rgb),
    .R_sel       (R_sel),
    .G_sel       (G_sel),
    .B_sel       (B_sel),
    .change_color(change_color)
  );

  always #5 Pixel_clock = ~Pixel_clock;

  // Reference model: a press is accepted when the synchronized level has been
  // 1 for D+1 consecutive cycles while released; release needs D+1 zeros.
  logic       m_s1 [2];
  logic       m_s2 [2];
  logic       m_last [2];
  logic       m_pressed [2];
  int         m_run [2];
  logic [2:0] m_idx;
  logic       m_chg;

  function automatic void model_clear();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_last[b] = 1'b0;
      m_pressed[b] = 1'b0; m_run[b] = 0;
    end
    m_idx = 3'd0;
    m_chg = 1'b0;
  endfunction

  function automatic void model_edge();
    logic ev [2];
    logic raw [2];
    raw[0] = btn_next;
    raw[1] = btn_load;
    for (int b = 0; b < 2; b++) begin
      if (m_s2[b] == m_last[b]) m_run[b]++;
      else begin
        m_run[b]  = 1;
        m_last[b] = m_s2[b];
      end
      ev[b] = 1'b0;
      if (!m_pressed[b] && m_s2[b] && m_run[b] == D + 1) begin
        ev[b] = 1'b1;
        m_pressed[b] = 1'b1;
      end else if (m_pressed[b] && !m_s2[b] && m_run[b] == D + 1) begin
        m_pressed[b] = 1'b0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    m_chg = ev[0] | ev[1];
    if (ev[1]) m_idx = sw_rgb;
    else if (ev[0]) m_idx = m_idx + 3'd1;
  endfunction

  task automatic tick();
    @(posedge Pixel_clock);
    if (Reset) model_clear();
    else model_edge();
    @(negedge Pixel_clock);
  endtask

  task automatic test_reset();
    int pulses = 0;
    Reset = 1'b1; btn_next = 1'b0; btn_load = 1'b0;
    #1;
    n_checks++;
    if ({R_sel, G_sel, B_sel, change_color} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {R_sel, G_sel, B_sel, change_color});
    end
    for (int i = 0; i < 3; i++) tick();
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (change_color === 1'b1) pulses++;
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
        n_fail++;
        $display("FAIL reset_release: got rgb=%b chg=%b expected rgb=%b chg=%b",
                 {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
      end
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_release_pulse: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_next_held();
    int pulses = 0;
    btn_next = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) btn_next = 1'b0;
      tick();
      if (change_color === 1'b1) pulses++;
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
        n_fail++;
        $display("FAIL next_held: got rgb=%b chg=%b expected rgb=%b chg=%b",
                 {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
      end
    end
    n_checks++;
    if (pulses != 1 || {R_sel, G_sel, B_sel} !== 3'b001) begin
      n_fail++;
      $display("FAIL next_held_summary: got pulses=%0d rgb=%b expected pulses=1 rgb=001",
               pulses, {R_sel, G_sel, B_sel});
    end
  endtask

  task automatic test_next_wrap();
    int pulses = 0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 16; i++) begin
        btn_next = (i < 7);
        tick();
        if (change_color === 1'b1) pulses++;
        n_checks++;
        if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
          n_fail++;
          $display("FAIL next_wrap: press %0d got rgb=%b chg=%b expected rgb=%b chg=%b",
                   p, {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
        end
      end
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== 3'(p + 1)) begin
        n_fail++;
        $display("FAIL next_wrap_step: press %0d got rgb=%b expected %b",
                 p, {R_sel, G_sel, B_sel}, 3'(p + 1));
      end
    end
    n_checks++;
    if (pulses != 8) begin
      n_fail++;
      $display("FAIL next_wrap_pulses: got %0d expected 8", pulses);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int at = -1;
    for (int i = 1; i <= 30; i++) begin
      btn_next = (i <= 8) ? ((((i - 1) / 2) % 2) == 0) : (i <= 22);
      tick();
      if (change_color === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
        n_fail++;
        $display("FAIL bounce: tick %0d got rgb=%b chg=%b expected rgb=%b chg=%b",
                 i, {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
      end
    end
    n_checks++;
    if (pulses != 1 || at < 14 || at > 16) begin
      n_fail++;
      $display("FAIL bounce_summary: got pulses=%0d at tick %0d expected 1 pulse at 14..16",
               pulses, at);
    end
  endtask

  task automatic test_load();
    int pulses = 0;
    sw_rgb = 3'b101;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        btn_load = (i < 7);
        tick();
        if (change_color === 1'b1) pulses++;
        n_checks++;
        if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
          n_fail++;
          $display("FAIL load: got rgb=%b chg=%b expected rgb=%b chg=%b",
                   {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
        end
      end
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== 3'b101 || pulses != p + 1) begin
        n_fail++;
        $display("FAIL load_summary: round %0d got rgb=%b pulses=%0d expected rgb=101 pulses=%0d",
                 p, {R_sel, G_sel, B_sel}, pulses, p + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    sw_rgb = 3'b110;
    for (int i = 0; i < 18; i++) begin
      btn_next = (i < 8);
      btn_load = (i < 8);
      tick();
      if (change_color === 1'b1) pulses++;
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
        n_fail++;
        $display("FAIL same_cycle: got rgb=%b chg=%b expected rgb=%b chg=%b",
                 {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
      end
    end
    n_checks++;
    if ({R_sel, G_sel, B_sel} !== 3'b110 || pulses != 1) begin
      n_fail++;
      $display("FAIL same_cycle_summary: got rgb=%b pulses=%0d expected rgb=110 pulses=1",
               {R_sel, G_sel, B_sel}, pulses);
    end
  endtask

  task automatic test_reset_midpress();
    int pulses = 0;
    int at = -1;
    btn_next = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
        n_fail++;
        $display("FAIL midpress_pre: got rgb=%b chg=%b expected rgb=%b chg=%b",
                 {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
      end
    end
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({R_sel, G_sel, B_sel, change_color} !== 4'b0000) begin
        n_fail++;
        $display("FAIL midpress_in_reset: got %b expected 0000",
                 {R_sel, G_sel, B_sel, change_color});
      end
      tick();
    end
    Reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (change_color === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
        n_fail++;
        $display("FAIL midpress_post: got rgb=%b chg=%b expected rgb=%b chg=%b",
                 {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
      end
    end
    n_checks++;
    if (pulses != 1 || at < 6 || at > 8 || {R_sel, G_sel, B_sel} !== 3'b001) begin
      n_fail++;
      $display("FAIL midpress_summary: got pulses=%0d at %0d rgb=%b expected 1 pulse at 6..8 rgb=001",
               pulses, at, {R_sel, G_sel, B_sel});
    end
    btn_next = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_random();
    int hold_n = 0;
    int hold_l = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold_n == 0) begin
        btn_next = 1'($urandom_range(0, 1));
        hold_n = $urandom_range(1, 9);
      end else hold_n--;
      if (hold_l == 0) begin
        btn_load = 1'($urandom_range(0, 1));
        hold_l = $urandom_range(1, 9);
      end else hold_l--;
      if ((i % 16) == 0) sw_rgb = 3'($urandom);
      Reset = ($urandom_range(0, 199) == 0);
      tick();
      Reset = 1'b0;
      n_checks++;
      if ({R_sel, G_sel, B_sel} !== m_idx || change_color !== m_chg) begin
        n_fail++;
        $display("FAIL random: cycle %0d got rgb=%b chg=%b expected rgb=%b chg=%b",
                 i, {R_sel, G_sel, B_sel}, change_color, m_idx, m_chg);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_next_held();
    test_next_wrap();
    test_bounce();
    test_load();
    test_back_to_back();
    test_reset_midpress();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
